// File: rtl/router_reg_param.sv
// Input-side register stage of the router: latches the header, forwards payload
// bytes to the channel FIFOs, parks one byte while the FIFO is full, and checks the
// running XOR parity against the packet's parity byte.
module router_reg_param #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 2,
   parameter int unsigned NUM_CH = 3,
   parameter int unsigned PAR_EN = 1,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              i_pkt_valid,
   input  logic [DATA_W-1:0] i_din,
   input  logic              i_fifo_full,
   input  logic              i_rst_int_reg,
   input  logic              i_detect_add,
   input  logic              i_lfd_state,
   input  logic              i_ld_state,
   input  logic              i_laf_state,
   input  logic              i_full_state,
   output logic [DATA_W-1:0] o_dout,
   output logic              o_parity_done,
   output logic              o_low_pkt_valid,
   output logic              o_err,
   output logic [CNT_W-1:0]  o_err_cnt
);

   logic [DATA_W-1:0] r_header;
   logic [DATA_W-1:0] r_dout;
   logic [DATA_W-1:0] r_hold;
   logic              r_hold_valid;
   logic              r_low_pkt_valid;
   logic [DATA_W-1:0] r_int_par;
   logic [DATA_W-1:0] r_pkt_par;
   logic              r_parity_done;
   logic              r_parity_done_d1;
   logic              r_err;
   logic [CNT_W-1:0]  r_err_cnt;

   logic              w_addr_ok;
   logic              w_par_bad;
   logic              w_cnt_max;

   assign w_addr_ok = 32'(i_din[ADDR_W-1:0]) < NUM_CH;
   // Compare only in the cycle right after parity_done rises.
   assign w_par_bad = (PAR_EN != 0) && r_parity_done && !r_parity_done_d1 &&
                      (r_int_par != r_pkt_par);
   assign w_cnt_max = (r_err_cnt == {CNT_W{1'b1}});

   // Header latch: only a valid destination address is accepted.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_header <= '0;
      end else if (i_detect_add && i_pkt_valid && w_addr_ok) begin
         r_header <= i_din;
      end
   end

   // Output byte path with a one-byte hold buffer for the FIFO-full case.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_dout       <= '0;
         r_hold       <= '0;
         r_hold_valid <= 1'b0;
      end else if (i_lfd_state) begin
         r_dout <= r_header;
      end else if (i_ld_state && !i_fifo_full) begin
         r_dout <= i_din;
      end else if (i_ld_state && i_fifo_full) begin
         r_hold       <= i_din;
         r_hold_valid <= 1'b1;
      end else if (i_laf_state && r_hold_valid) begin
         r_dout       <= r_hold;
         r_hold_valid <= 1'b0;
      end
   end

   // Flags that pkt_valid dropped during load, i.e. the parity byte has arrived.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_low_pkt_valid <= 1'b0;
      end else if (i_rst_int_reg) begin
         r_low_pkt_valid <= 1'b0;
      end else if (i_ld_state && !i_pkt_valid) begin
         r_low_pkt_valid <= 1'b1;
      end
   end

   // Running XOR over header and payload; a byte diverted into hold still counts.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_int_par <= '0;
      end else if (i_detect_add) begin
         r_int_par <= '0;
      end else if (i_lfd_state && i_pkt_valid) begin
         r_int_par <= r_int_par ^ r_header;
      end else if (i_ld_state && i_pkt_valid && !i_full_state) begin
         r_int_par <= r_int_par ^ i_din;
      end
   end

   // Parity byte capture, directly or deferred through hold when the FIFO was full.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_pkt_par     <= '0;
         r_parity_done <= 1'b0;
      end else if (i_detect_add) begin
         r_pkt_par     <= '0;
         r_parity_done <= 1'b0;
      end else if (i_ld_state && !i_pkt_valid && !i_fifo_full) begin
         r_pkt_par     <= i_din;
         r_parity_done <= 1'b1;
      end else if (i_laf_state && r_low_pkt_valid && !r_parity_done) begin
         r_pkt_par     <= r_hold;
         r_parity_done <= 1'b1;
      end
   end

   // Delayed parity_done for rising-edge detection.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_parity_done_d1 <= 1'b0;
      end else begin
         r_parity_done_d1 <= r_parity_done;
      end
   end

   // Sticky per-packet error and saturating count of errored packets.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_err     <= 1'b0;
         r_err_cnt <= '0;
      end else if (i_detect_add) begin
         r_err <= 1'b0;
      end else if (w_par_bad) begin
         r_err <= 1'b1;
         if (!w_cnt_max) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
         end
      end
   end

   assign o_dout          = r_dout;
   assign o_parity_done   = r_parity_done;
   assign o_low_pkt_valid = r_low_pkt_valid;
   assign o_err           = r_err;
   assign o_err_cnt       = r_err_cnt;

endmodule

// File: tb/tb_router_reg_param.sv
// Bench for router_reg_param: default instance, a 2-bit counter instance for
// saturation, and a parity-disabled instance, all driven by the same stimulus.
module tb_router_reg_param;

   typedef struct {
      logic       rstn, pv;
      logic [7:0] din;
      logic       ff, rir, da, lfd, ld, laf, fs;
   } in_t;

   typedef struct {
      logic [7:0] dout;
      logic       pd, lpv, err;
      logic [7:0] cnt;
      logic [1:0] cnt2;
   } exp_t;

   typedef struct {
      in_t  i;
      exp_t e;
   } vec_t;

   logic       clk;
   logic       rstn, pkt_valid, fifo_full, rst_int_reg;
   logic       detect_add, lfd_state, ld_state, laf_state, full_state;
   logic [7:0] din;

   logic [7:0] dout_a, dout_s, dout_n;
   logic       pd_a, pd_s, pd_n, lpv_a, lpv_s, lpv_n, err_a, err_s, err_n;
   logic [7:0] cnt_a, cnt_n;
   logic [1:0] cnt_s;

   int         n_pass = 0;
   int         n_total = 0;
   int         n_step = 0;
   exp_t       sb[$];
   logic [7:0] e_dout = 8'h00;
   logic [7:0] e_cnt = 8'h00;
   logic [1:0] e_cnt2 = 2'd0;

   router_reg_param dut (
      .clk(clk), .rstn(rstn), .i_pkt_valid(pkt_valid), .i_din(din),
      .i_fifo_full(fifo_full), .i_rst_int_reg(rst_int_reg), .i_detect_add(detect_add),
      .i_lfd_state(lfd_state), .i_ld_state(ld_state), .i_laf_state(laf_state),
      .i_full_state(full_state), .o_dout(dout_a), .o_parity_done(pd_a),
      .o_low_pkt_valid(lpv_a), .o_err(err_a), .o_err_cnt(cnt_a)
   );

   router_reg_param #(.CNT_W(2)) dut_sat (
      .clk(clk), .rstn(rstn), .i_pkt_valid(pkt_valid), .i_din(din),
      .i_fifo_full(fifo_full), .i_rst_int_reg(rst_int_reg), .i_detect_add(detect_add),
      .i_lfd_state(lfd_state), .i_ld_state(ld_state), .i_laf_state(laf_state),
      .i_full_state(full_state), .o_dout(dout_s), .o_parity_done(pd_s),
      .o_low_pkt_valid(lpv_s), .o_err(err_s), .o_err_cnt(cnt_s)
   );

   router_reg_param #(.PAR_EN(0)) dut_np (
      .clk(clk), .rstn(rstn), .i_pkt_valid(pkt_valid), .i_din(din),
      .i_fifo_full(fifo_full), .i_rst_int_reg(rst_int_reg), .i_detect_add(detect_add),
      .i_lfd_state(lfd_state), .i_ld_state(ld_state), .i_laf_state(laf_state),
      .i_full_state(full_state), .o_dout(dout_n), .o_parity_done(pd_n),
      .o_low_pkt_valid(lpv_n), .o_err(err_n), .o_err_cnt(cnt_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Columns: rstn pv din ff rir da lfd ld laf fs | dout pd lpv err cnt cnt2
   function automatic vec_t v(input int rs, input int pv, input int di, input int ff,
                              input int rir, input int da, input int lfd, input int ld,
                              input int laf, input int fs, input int dout, input int pd,
                              input int lpv, input int err, input int cnt, input int cnt2);
      vec_t r;
      r.i.rstn = rs[0];  r.i.pv = pv[0];   r.i.din = di[7:0]; r.i.ff = ff[0];
      r.i.rir  = rir[0]; r.i.da = da[0];   r.i.lfd = lfd[0];  r.i.ld = ld[0];
      r.i.laf  = laf[0]; r.i.fs = fs[0];
      r.e.dout = dout[7:0]; r.e.pd = pd[0]; r.e.lpv = lpv[0]; r.e.err = err[0];
      r.e.cnt  = cnt[7:0];  r.e.cnt2 = cnt2[1:0];
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s step %0d: got %0h, want %0h", name, n_step, act, exp);
   endtask

   // Drive one cycle, queue its expectation, compare after the edge.
   task automatic step(input vec_t x);
      exp_t e;
      @(negedge clk);
      rstn = x.i.rstn; pkt_valid = x.i.pv; din = x.i.din; fifo_full = x.i.ff;
      rst_int_reg = x.i.rir; detect_add = x.i.da; lfd_state = x.i.lfd;
      ld_state = x.i.ld; laf_state = x.i.laf; full_state = x.i.fs;
      sb.push_back(x.e);
      @(posedge clk);
      #1;
      n_step++;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         e_dout = e.dout;
         chk("dout", dout_a, e.dout);
         chk("parity_done", pd_a, e.pd);
         chk("low_pkt_valid", lpv_a, e.lpv);
         chk("err", err_a, e.err);
         chk("err_cnt", cnt_a, e.cnt);
         chk("sat_dout", dout_s, e.dout);
         chk("sat_err", err_s, e.err);
         chk("sat_err_cnt", cnt_s, e.cnt2);
         chk("np_parity_done", pd_n, e.pd);
         chk("np_err", err_n, 0);
         chk("np_err_cnt", cnt_n, 0);
      end
   endtask

   // Full packet with three payload bytes; expectations come from the packet itself.
   task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] par);
      logic bad;
      bad = (par != (hdr ^ d0 ^ d1 ^ d2));
      step(v(1, 1, hdr, 0, 0, 1, 0, 0, 0, 0, e_dout, 0, 0, 0, e_cnt, e_cnt2));
      step(v(1, 1, d0,  0, 0, 0, 1, 0, 0, 0, hdr, 0, 0, 0, e_cnt, e_cnt2));
      step(v(1, 1, d0,  0, 0, 0, 0, 1, 0, 0, d0,  0, 0, 0, e_cnt, e_cnt2));
      step(v(1, 1, d1,  0, 0, 0, 0, 1, 0, 0, d1,  0, 0, 0, e_cnt, e_cnt2));
      step(v(1, 1, d2,  0, 0, 0, 0, 1, 0, 0, d2,  0, 0, 0, e_cnt, e_cnt2));
      step(v(1, 0, par, 0, 0, 0, 0, 1, 0, 0, par, 1, 1, 0, e_cnt, e_cnt2));
      if (bad) begin
         e_cnt = e_cnt + 8'd1;
         if (e_cnt2 != 2'd3) e_cnt2 = e_cnt2 + 2'd1;
      end
      step(v(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, par, 1, 0, int'(bad), e_cnt, e_cnt2));
      step(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, par, 1, 0, int'(bad), e_cnt, e_cnt2));
   endtask

   vec_t tbl[17];

   initial begin
      rstn = 1'b0; pkt_valid = 1'b0; din = 8'h00; fifo_full = 1'b0; rst_int_reg = 1'b0;
      detect_add = 1'b0; lfd_state = 1'b0; ld_state = 1'b0; laf_state = 1'b0;
      full_state = 1'b0;

      // Reset, good packet 0x0D/11/22/33/0D, then invalid address 0x03 keeps header.
      tbl[0]  = v(0, 0, 'h00, 0, 0, 0, 0, 0, 0, 0, 'h00, 0, 0, 0, 0, 0);
      tbl[1]  = v(1, 0, 'h00, 0, 0, 0, 0, 0, 0, 0, 'h00, 0, 0, 0, 0, 0);
      tbl[2]  = v(1, 1, 'h0D, 0, 0, 1, 0, 0, 0, 0, 'h00, 0, 0, 0, 0, 0);
      tbl[3]  = v(1, 1, 'h11, 0, 0, 0, 1, 0, 0, 0, 'h0D, 0, 0, 0, 0, 0);
      tbl[4]  = v(1, 1, 'h11, 0, 0, 0, 0, 1, 0, 0, 'h11, 0, 0, 0, 0, 0);
      tbl[5]  = v(1, 1, 'h22, 0, 0, 0, 0, 1, 0, 0, 'h22, 0, 0, 0, 0, 0);
      tbl[6]  = v(1, 1, 'h33, 0, 0, 0, 0, 1, 0, 0, 'h33, 0, 0, 0, 0, 0);
      tbl[7]  = v(1, 0, 'h0D, 0, 0, 0, 0, 1, 0, 0, 'h0D, 1, 1, 0, 0, 0);
      tbl[8]  = v(1, 0, 'h00, 0, 1, 0, 0, 0, 0, 0, 'h0D, 1, 0, 0, 0, 0);
      tbl[9]  = v(1, 0, 'h00, 0, 0, 0, 0, 0, 0, 0, 'h0D, 1, 0, 0, 0, 0);
      tbl[10] = v(1, 1, 'h03, 0, 0, 1, 0, 0, 0, 0, 'h0D, 0, 0, 0, 0, 0);
      tbl[11] = v(1, 1, 'h00, 0, 0, 0, 1, 0, 0, 0, 'h0D, 0, 0, 0, 0, 0);
      tbl[12] = v(1, 1, 'h11, 0, 0, 0, 0, 1, 0, 0, 'h11, 0, 0, 0, 0, 0);
      tbl[13] = v(1, 1, 'h22, 0, 0, 0, 0, 1, 0, 0, 'h22, 0, 0, 0, 0, 0);
      tbl[14] = v(1, 1, 'h33, 0, 0, 0, 0, 1, 0, 0, 'h33, 0, 0, 0, 0, 0);
      tbl[15] = v(1, 0, 'h0D, 0, 0, 0, 0, 1, 0, 0, 'h0D, 1, 1, 0, 0, 0);
      tbl[16] = v(1, 0, 'h00, 0, 1, 0, 0, 0, 0, 0, 'h0D, 1, 0, 0, 0, 0);
      for (int k = 0; k < 17; k++) step(tbl[k]);

      // Bad parity byte 0x0C: err one cycle after parity_done, count 1.
      send_pkt(8'h0D, 8'h11, 8'h22, 8'h33, 8'h0C);

      // FIFO full on payload 0x22: dout holds 0x11, then 0x22 in LOAD_AFTER_FULL.
      step(v(1, 1, 'h0D, 0, 0, 1, 0, 0, 0, 0, e_dout, 0, 0, 0, e_cnt, e_cnt2));
      step(v(1, 1, 'h11, 0, 0, 0, 1, 0, 0, 0, 'h0D, 0, 0, 0, e_cnt, e_cnt2));
      step(v(1, 1, 'h11, 0, 0, 0, 0, 1, 0, 0, 'h11, 0, 0, 0, e_cnt, e_cnt2));
      step(v(1, 1, 'h22, 1, 0, 0, 0, 1, 0, 0, 'h11, 0, 0, 0, e_cnt, e_cnt2));
      step(v(1, 1, 'h33, 1, 0, 0, 0, 0, 0, 1, 'h11, 0, 0, 0, e_cnt, e_cnt2));
      step(v(1, 1, 'h33, 0, 0, 0, 0, 0, 1, 0, 'h22, 0, 0, 0, e_cnt, e_cnt2));
      step(v(1, 1, 'h33, 0, 0, 0, 0, 1, 0, 0, 'h33, 0, 0, 0, e_cnt, e_cnt2));
      step(v(1, 0, 'h0D, 0, 0, 0, 0, 1, 0, 0, 'h0D, 1, 1, 0, e_cnt, e_cnt2));
      step(v(1, 0, 'h00, 0, 1, 0, 0, 0, 0, 0, 'h0D, 1, 0, 0, e_cnt, e_cnt2));
      step(v(1, 0, 'h00, 0, 0, 0, 0, 0, 0, 0, 'h0D, 1, 0, 0, e_cnt, e_cnt2));

      // Parity byte while full: capture deferred to LOAD_AFTER_FULL.
      step(v(1, 1, 'h0D, 0, 0, 1, 0, 0, 0, 0, e_dout, 0, 0, 0, e_cnt, e_cnt2));
      step(v(1, 1, 'h11, 0, 0, 0, 1, 0, 0, 0, 'h0D, 0, 0, 0, e_cnt, e_cnt2));
      step(v(1, 1, 'h11, 0, 0, 0, 0, 1, 0, 0, 'h11, 0, 0, 0, e_cnt, e_cnt2));
      step(v(1, 1, 'h22, 0, 0, 0, 0, 1, 0, 0, 'h22, 0, 0, 0, e_cnt, e_cnt2));
      step(v(1, 1, 'h33, 0, 0, 0, 0, 1, 0, 0, 'h33, 0, 0, 0, e_cnt, e_cnt2));
      step(v(1, 0, 'h0D, 1, 0, 0, 0, 1, 0, 0, 'h33, 0, 1, 0, e_cnt, e_cnt2));
      step(v(1, 0, 'h0D, 1, 0, 0, 0, 0, 0, 1, 'h33, 0, 1, 0, e_cnt, e_cnt2));
      step(v(1, 0, 'h0D, 0, 0, 0, 0, 0, 1, 0, 'h0D, 1, 1, 0, e_cnt, e_cnt2));
      step(v(1, 0, 'h00, 0, 1, 0, 0, 0, 0, 0, 'h0D, 1, 0, 0, e_cnt, e_cnt2));
      step(v(1, 0, 'h00, 0, 0, 0, 0, 0, 0, 0, 'h0D, 1, 0, 0, e_cnt, e_cnt2));

      // Reset after two payload bytes clears everything including err_cnt.
      step(v(1, 1, 'h0D, 0, 0, 1, 0, 0, 0, 0, e_dout, 0, 0, 0, e_cnt, e_cnt2));
      step(v(1, 1, 'h11, 0, 0, 0, 1, 0, 0, 0, 'h0D, 0, 0, 0, e_cnt, e_cnt2));
      step(v(1, 1, 'h11, 0, 0, 0, 0, 1, 0, 0, 'h11, 0, 0, 0, e_cnt, e_cnt2));
      step(v(1, 1, 'h22, 0, 0, 0, 0, 1, 0, 0, 'h22, 0, 0, 0, e_cnt, e_cnt2));
      e_cnt  = 8'h00;
      e_cnt2 = 2'd0;
      step(v(0, 1, 'h33, 0, 0, 0, 0, 1, 0, 0, 'h00, 0, 0, 0, 0, 0));
      step(v(1, 0, 'h00, 0, 0, 0, 0, 0, 0, 0, 'h00, 0, 0, 0, 0, 0));
      send_pkt(8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D);

      // Five bad packets across all three addresses: 8-bit count 5, 2-bit count 3.
      for (int k = 0; k < 5; k++) begin
         logic [7:0] h, a, b, c;
         h = 8'(((k + 1) << 2) | (k % 3));
         a = 8'(k * 17 + 3);
         b = 8'(k * 29 + 7);
         c = 8'(k * 43 + 1);
         send_pkt(h, a, b, c, h ^ a ^ b ^ c ^ 8'h80);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/router_reg_param.md
Name: router_reg_param

Overview:
- Parametrised input-side register stage of the router.
- Latches and validates the header, forwards data bytes to the destination FIFOs, and buffers one byte when the FIFO is full.
- Computes the running XOR parity, compares it against the packet parity byte, and raises a sticky error with a saturating error counter.
- Driven by the router FSM state strobes; sits between the input pins and the per-channel FIFOs.

Parameters:
- DATA_W, 8, byte width of din/dout/parity.
- ADDR_W, 2, low header bits that form the destination address.
- NUM_CH, 3, number of valid channels; address valid iff din[ADDR_W-1:0] < NUM_CH.
- PAR_EN, 1, 1 = parity compare enabled; 0 = err never set.
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rstn  in  1  synchronous, active-low reset.
- pkt_valid  in  1  input byte valid / packet in progress.
- din  in  DATA_W  input byte.
- fifo_full  in  1  selected FIFO full.
- rst_int_reg  in  1  clears low_pkt_valid.
- detect_add  in  1  FSM DECODE_ADDRESS state.
- lfd_state  in  1  FSM LOAD_FIRST_DATA state.
- ld_state  in  1  FSM LOAD_DATA state.
- laf_state  in  1  FSM LOAD_AFTER_FULL state.
- full_state  in  1  FSM FIFO_FULL_STATE state.
- dout  out  DATA_W  byte to FIFO.
- parity_done  out  1  parity byte captured (sticky per packet).
- low_pkt_valid  out  1  pkt_valid fell during load.
- err  out  1  parity mismatch (sticky per packet).
- err_cnt  out  CNT_W  saturating count of errored packets.

Behaviour:
- Reset (rstn=0 at clk edge): dout, parity_done, low_pkt_valid, err, err_cnt, and the internal header, hold, hold_valid, int_par and pkt_par registers all go to 0. Reset mid-packet discards the packet; the next packet is handled normally.
- Header: header <= din when detect_add & pkt_valid & (din[ADDR_W-1:0] < NUM_CH); otherwise header is unchanged.
- dout (priority order, 1-cycle latency):
  1. lfd_state: dout <= header.
  2. ld_state & !fifo_full: dout <= din.
  3. ld_state & fifo_full: hold <= din, hold_valid <= 1, dout holds.
  4. laf_state & hold_valid: dout <= hold, hold_valid <= 0.
  5. Otherwise: dout holds.
- low_pkt_valid: rst_int_reg clears it (highest priority after reset); ld_state & !pkt_valid sets it; otherwise it holds.
- int_par:
  - detect_add clears it.
  - lfd_state & pkt_valid: int_par ^= header.
  - ld_state & pkt_valid & !full_state: int_par ^= din. This includes a byte diverted into hold.
- Parity capture:
  - ld_state & !pkt_valid & !fifo_full: pkt_par <= din, parity_done <= 1.
  - ld_state & !pkt_valid & fifo_full: byte goes to hold; capture is deferred.
  - laf_state & low_pkt_valid & !parity_done: pkt_par <= hold, parity_done <= 1.
  - parity_done stays 1 until detect_add clears it.
- err:
  - On the cycle after parity_done rises 0->1: if PAR_EN and int_par != pkt_par, err <= 1 and err_cnt increments.
  - err_cnt saturates at 2^CNT_W-1, no wrap.
  - err clears on detect_add; err_cnt clears only on reset.
- Simultaneous events: detect_add clears per-packet state (parity_done, err, int_par, pkt_par) with priority over set terms in the same cycle. Reset overrides everything.
- PAR_EN=0: parity_done behaves as normal; err and err_cnt stay 0.
- At most one byte is buffered in hold; the FSM guarantees laf_state follows full_state before the next ld_state.

Test Plan:
- Good packet: header 0x0D (addr 1), payload 0x11, 0x22, 0x33, parity 0x0D -> dout sequence 0x0D, 0x11, 0x22, 0x33, 0x0D; parity_done=1; err=0; err_cnt=0.
- Bad parity: same packet with parity byte 0x0C -> err=1 one cycle after parity_done rises; err_cnt=1; err clears at the next detect_add.
- FIFO full: fifo_full=1 while din=0x22 in ld_state -> dout holds 0x11; then in laf_state dout=0x22; int_par still correct; err=0.
- Parity byte while full: parity 0x0D arrives with fifo_full=1 -> parity_done=0 until laf_state; then pkt_par=0x0D, parity_done=1, err=0.
- Invalid address with NUM_CH=3: din=0x03 during detect_add -> header retains its previous value. Saturation with CNT_W=2: five bad packets -> err_cnt=3.
- Reset mid-packet: rstn=0 after two payload bytes -> all outputs 0; a following good packet yields err=0 and parity_done=1.
